// File: rtl/btn_pkg.sv
// Shared push-button definitions: debounce FSM state encoding and the pressed level.
// Used by button_pulse_gen, the pulse-to-toggle stage and later button stages.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_e;

   localparam logic PRESSED = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, async active-high reset to 0.
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/button_pulse_gen.sv
// Debounces a raw push-button into a registered level and a one-cycle pulse per press.
// Optional auto-repeat while held is built when BTN_AUTOREPEAT_EN is defined.
module button_pulse_gen
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_DELAY    = 5000,
   parameter int unsigned REPEAT_PERIOD   = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic in_raw,
   output logic pulse,
   output logic level
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc_c;
   logic             pulse_q, pulse_d;
   logic             level_q, level_d;
   logic             rpt_fire_c;

   sync_2ff u_sync (
      .clock (clock),
      .reset (reset),
      .d     (in_raw),
      .q     (s)
   );

   // Saturating increment: the counter never wraps even if the limit is missed.
   assign cnt_inc_c = (cnt_q < CNT_LAST) ? cnt_q + CNT_W'(1) : cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      level_d = level_q;
      case (state_q)
         IDLE: begin
            if (s == PRESSED) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         PRESS_WAIT: begin
            if (s != PRESSED) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               pulse_d = 1'b1;
               level_d = PRESSED;
            end else begin
               cnt_d = cnt_inc_c;
            end
         end
         HELD: begin
            if (s != PRESSED) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_W'(1);
            end else begin
               pulse_d = rpt_fire_c;
            end
         end
         RELEASE_WAIT: begin
            if (s == PRESSED) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               level_d = ~PRESSED;
            end else begin
               cnt_d = cnt_inc_c;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             rpt_phase_q, rpt_phase_d;
   logic [RPT_W-1:0] rpt_limit_c;

   // Phase 0 times the initial delay, phase 1 the repeat period; frozen in RELEASE_WAIT.
   always_comb begin
      rpt_d       = rpt_q;
      rpt_phase_d = rpt_phase_q;
      rpt_fire_c  = 1'b0;
      rpt_limit_c = rpt_phase_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
      case (state_q)
         IDLE, PRESS_WAIT: begin
            rpt_d       = '0;
            rpt_phase_d = 1'b0;
         end
         HELD: begin
            if (s == PRESSED) begin
               if (rpt_q == rpt_limit_c) begin
                  rpt_fire_c  = 1'b1;
                  rpt_d       = '0;
                  rpt_phase_d = 1'b1;
               end else begin
                  rpt_d = rpt_q + RPT_W'(1);
               end
            end
         end
         default: begin
            rpt_d       = rpt_q;
            rpt_phase_d = rpt_phase_q;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rpt_q       <= '0;
         rpt_phase_q <= 1'b0;
      end else begin
         rpt_q       <= rpt_d;
         rpt_phase_q <= rpt_phase_d;
      end
   end
`else
   logic unused_rpt_cfg;

   assign rpt_fire_c     = 1'b0;
   assign unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

   assign pulse = pulse_q;
   assign level = level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen: directed scenarios plus random bounce,
// compared every cycle against a run-length reference model.
module tb_button_pulse_gen;

   localparam int unsigned DEB  = 4;
   localparam int unsigned RDLY = 10;
   localparam int unsigned RPER = 3;

   logic clock = 1'b0;
   logic reset;
   logic in_raw;
   logic pulse;
   logic level;
   logic tgl;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic m_h1, m_h2, m_level, m_pulse, m_tgl;
   int   m_run, m_held_t;

   int seen_pulses;

   always #5 clock = ~clock;

   button_pulse_gen #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RDLY),
      .REPEAT_PERIOD   (RPER)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .in_raw (in_raw),
      .pulse  (pulse),
      .level  (level)
   );

   // Downstream pulse-to-toggle stand-in
   always_ff @(posedge clock or posedge reset) begin
      if (reset)      tgl <= 1'b0;
      else if (pulse) tgl <= ~tgl;
   end

   task automatic check(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int expv);
      checks++;
      assert (obs == expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_h1 = 1'b0; m_h2 = 1'b0;
      m_level = 1'b0; m_pulse = 1'b0; m_tgl = 1'b0;
      m_run = 0; m_held_t = 0;
   endtask

   // Level flips after DEB consecutive synced samples differing from it.
   task automatic model_edge();
      logic s;
      m_tgl = m_tgl ^ m_pulse;
      s     = m_h2;
      m_h2  = m_h1;
      m_h1  = in_raw;
      m_pulse = 1'b0;
      if (s != m_level) begin
         m_run++;
         if (m_run == int'(DEB)) begin
            m_level = s;
            m_run   = 0;
            if (s) begin
               m_pulse  = 1'b1;
               m_held_t = 0;
            end
         end
      end else begin
         if (m_level && m_run == 0) begin
            m_held_t++;
`ifdef BTN_AUTOREPEAT_EN
            if (m_held_t == int'(RDLY) ||
                (m_held_t > int'(RDLY) && ((m_held_t - int'(RDLY)) % int'(RPER)) == 0))
               m_pulse = 1'b1;
`endif
         end
         m_run = 0;
      end
   endtask

   task automatic step(input logic v);
      in_raw = v;
      @(posedge clock);
      model_edge();
      #1;
      if (pulse === 1'b1) seen_pulses++;
      check("pulse", pulse, m_pulse);
      check("level", level, m_level);
      check("toggle", tgl, m_tgl);
   endtask

   task automatic do_reset_async();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_pulse", pulse, 1'b0);
      check("rst_level", level, 1'b0);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int first;
      int exp_rpt;
      logic v;
      int len;

      reset  = 1'b1;
      in_raw = 1'b0;
      seen_pulses = 0;
      model_reset();
      #2;
      check("reset_pulse", pulse, 1'b0);
      check("reset_level", level, 1'b0);
      #10;
      reset = 1'b0;

      for (int i = 0; i < 6; i++) step(1'b0);

      // 1: clean press, pulse DEB+1 edges after capture
      first = -1;
      for (int i = 0; i < 10; i++) begin
         step(1'b1);
         if (pulse === 1'b1 && first < 0) first = i;
      end
      check_int("press_latency", first, int'(DEB) + 1);
      for (int i = 0; i < 10; i++) step(1'b0);

      // 2: press bounce -> one pulse, DEB+1 after final rise
      seen_pulses = 0;
      step(1'b1); step(1'b1); step(1'b0);
      first = -1;
      for (int i = 0; i < 10; i++) begin
         step(1'b1);
         if (pulse === 1'b1 && first < 0) first = i;
      end
      check_int("bounce_pulses", seen_pulses, 1);
      check_int("bounce_latency", first, int'(DEB) + 1);

      // 3: release bounce -> no pulse, level falls DEB+1 after final fall
      seen_pulses = 0;
      step(1'b0); step(1'b0); step(1'b1);
      check("relbounce_level", level, 1'b1);
      first = -1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0);
         if (level === 1'b0 && first < 0) first = i;
      end
      check_int("release_pulses", seen_pulses, 0);
      check_int("release_latency", first, int'(DEB) + 1);

      // 4: reset mid-press, then full debounce required
      for (int i = 0; i < 4; i++) step(1'b1);
      do_reset_async();
      first = -1;
      for (int i = 0; i < 10; i++) begin
         step(1'b1);
         if (pulse === 1'b1 && first < 0) first = i;
      end
      check_int("post_reset_latency", first, int'(DEB) + 1);
      do_reset_async();
      for (int i = 0; i < 10; i++) step(1'b1);
      for (int i = 0; i < 10; i++) step(1'b0);

      // 5: hold 30 cycles after accept
      seen_pulses = 0;
      for (int i = 0; i < int'(DEB) + 2 + 30; i++) step(1'b1);
`ifdef BTN_AUTOREPEAT_EN
      exp_rpt = 7;
`else
      exp_rpt = 0;
`endif
      check_int("hold_pulses", seen_pulses, 1 + exp_rpt);
      for (int i = 0; i < 10; i++) step(1'b0);

      // 6: three clean presses into the toggle stage
      do_reset_async();
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 8; i++) step(1'b1);
         for (int i = 0; i < 8; i++) step(1'b0);
         check("chain_toggle", tgl, (p % 2 == 0) ? 1'b1 : 1'b0);
      end

      // Random bounce segments
      for (int k = 0; k < 60; k++) begin
         v = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 16)) : int'($urandom_range(1, 5));
         for (int i = 0; i < len; i++) step(v);
         if ($urandom_range(0, 19) == 0) do_reset_async();
      end
      for (int i = 0; i < 10; i++) step(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
